instruction_memaccess: RTL and testbench
========================================

INSTRUCTION_MEMACCESS -- requirements
Module: instruction_memaccess

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstf  in  1  reset, synchronous, active-high.
REQ-004 t_instr  in  32  instruction from execute; t_instr_valid in 1; t_instr_ready out 1.
REQ-005 iPC  in  32, iDecodedOP  in  5, alu_result  in  32 (effective address or ALU value), rs2Value  in  32 (store data).
REQ-006 dbus_addr  out  32 (word-aligned), dbus_wdata  out  32, dbus_wstrb  out  4, dbus_we  out  1, dbus_req_valid  out  1, dbus_req_ready  in  1.
REQ-007 dbus_rsp_valid  in  1, dbus_rdata  in  32  read response.
REQ-008 i_instr  out  32, i_instr_valid  out  1, i_instr_ready  in  1  toward writeback.
REQ-009 oPC  out  32, oDecodedOP  out  5, maAlu_rdValue  out  32  registered to writeback.
REQ-010 ma_misaligned  out  1  misaligned-access flag, held with output entry.

Function
REQ-011 Opcode is t_instr[6:0], funct3 is t_instr[14:12]; LOAD=7'b0000011, STORE=7'b0100011; all other opcodes are non-memory.
REQ-012 States SHALL be IDLE, REQ, RSP; output is a single-entry register (out_valid).
REQ-013 t_instr_ready SHALL equal (state==IDLE) && (!out_valid || i_instr_ready).
REQ-014 Non-memory accept: next cycle out_valid=1, maAlu_rdValue=alu_result, oPC/oDecodedOP/i_instr captured; latency 1.
REQ-015 Load/store accept: capture instruction, PC, op, address, data; go to REQ.
REQ-016 REQ: dbus_req_valid=1, addr/wdata/wstrb/we stable until dbus_req_ready; on handshake a load goes to RSP, a store goes to IDLE and loads output entry (maAlu_rdValue=0).
REQ-017 RSP: on dbus_rsp_valid, extract per funct3 and load output entry; go to IDLE. Min load latency 3 cycles (accept, REQ, RSP) with ready/rsp same-cycle.
REQ-018 Load extract: LB/LBU byte lane alu_result[1:0], sign/zero-extend; LH/LHU half lane alu_result[1], sign/zero-extend; LW full word.
REQ-019 Store: SB wstrb=4'b0001<<addr[1:0], wdata=byte replicated x4; SH wstrb=4'b0011<<(2*addr[1]), half replicated x2; SW wstrb=4'hF.
REQ-020 dbus_addr SHALL be {alu_result[31:2],2'b00}; dbus_we=1 only for stores.
REQ-021 i_instr_valid=out_valid; entry clears on i_instr_ready unless a new entry loads the same cycle (simultaneous consume+load SHALL keep out_valid=1 with new data).
REQ-022 Completion of a memory op into a full, unconsumed output register SHALL NOT occur: memory op is accepted only when REQ-013 holds, and no other accept occurs while state!=IDLE.
REQ-023 dbus_rsp_valid outside RSP SHALL be ignored.

Reset
REQ-024 On rstf=1 at a clock edge: state=IDLE, out_valid=0, dbus_req_valid=0, ma_misaligned=0, maAlu_rdValue=0, i_instr=0, oPC=0, oDecodedOP=0.
REQ-025 Reset mid-transaction SHALL abandon it; the late response is dropped per REQ-023.
REQ-026 t_instr_ready SHALL be 0 while rstf=1.

Configuration
REQ-027 Macro MA_MISALIGN_TRAP_EN: defined -> halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no bus request, load output entry next cycle with ma_misaligned=1, maAlu_rdValue=alu_result.
REQ-028 Undefined -> ma_misaligned tied 0; low address bits ignored for alignment, access proceeds on the aligned word with lanes per REQ-018/019.

Verification
REQ-029 ALU op alu_result=32'h1234, i_instr_ready=1 -> next cycle i_instr_valid=1, maAlu_rdValue=32'h1234.
REQ-030 LB addr 32'h103, dbus_rdata=32'h80FF_0000, ready/rsp immediate -> dbus_addr=32'h100, maAlu_rdValue=32'hFFFF_FF80; LBU -> 32'h0000_0080.
REQ-031 SH addr 32'h202, rs2Value=32'hABCD_1234 -> dbus_wstrb=4'b1100, dbus_wdata=32'h1234_1234, dbus_we=1.
REQ-032 Load with dbus_req_ready low 5 cycles and i_instr_ready low -> request held stable, t_instr_ready=0 throughout, entry held until ready.
REQ-033 rstf pulsed while in RSP, then dbus_rsp_valid -> no i_instr_valid, state IDLE.
REQ-034 With MA_MISALIGN_TRAP_EN, LW addr 32'h301 -> no dbus_req_valid, ma_misaligned=1 next cycle.

Source files
------------

// File: rtl/instruction_memaccess_if.sv
// Data-bus bundle between the memory-access stage and the data memory.
// The master side issues requests; the slave side returns ready and read data.
interface instruction_memaccess_if;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_we;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_addr, dbus_wdata, dbus_wstrb, dbus_we, dbus_req_valid,
        input  dbus_req_ready, dbus_rsp_valid, dbus_rdata
    );

    modport slave (
        input  dbus_addr, dbus_wdata, dbus_wstrb, dbus_we, dbus_req_valid,
        output dbus_req_ready, dbus_rsp_valid, dbus_rdata
    );
endinterface

// File: rtl/instruction_memaccess.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores on the data bus.
// Optional macro MA_MISALIGN_TRAP_EN: misaligned half/word accesses complete without a bus request.
//
// state | meaning
// IDLE  | ready for a new instruction (if the output entry can take a result)
// REQ   | data-bus request presented, waiting for dbus_req_ready
// RSP   | load issued, waiting for dbus_rsp_valid
module instruction_memaccess (
    input  logic        clk,
    input  logic        rstf,
    input  logic [31:0] t_instr,
    input  logic        t_instr_valid,
    output logic        t_instr_ready,
    input  logic [31:0] iPC,
    input  logic [4:0]  iDecodedOP,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2Value,
    instruction_memaccess_if.master dbus,
    output logic [31:0] i_instr,
    output logic        i_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] oPC,
    output logic [4:0]  oDecodedOP,
    output logic [31:0] maAlu_rdValue,
    output logic        ma_misaligned
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_txn_instr;
    logic [31:0] r_txn_pc;
    logic [4:0]  r_txn_op;
    logic [31:0] r_txn_addr;
    logic [31:0] r_txn_wdata;
    logic [3:0]  r_txn_wstrb;
    logic        r_txn_we;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [4:0]  r_out_op;
    logic [31:0] r_out_rd;
    logic        r_out_mis;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_trap;
    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [2:0]  w_txn_funct3;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    logic        w_load_out;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [4:0]  w_out_op;
    logic [31:0] w_out_rd;
    logic        w_out_mis;

    assign w_opcode   = t_instr[6:0];
    assign w_funct3   = t_instr[14:12];
    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);
    assign w_is_mem   = w_is_load || w_is_store;

`ifdef MA_MISALIGN_TRAP_EN
    assign w_trap = w_is_mem &&
                    (((w_funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((w_funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
`else
    assign w_trap = 1'b0;
`endif

    // Output entry can take a new result this cycle if empty or being drained.
    assign t_instr_ready = !rstf && (r_state == IDLE) && (!r_out_valid || i_instr_ready);
    assign w_accept      = t_instr_valid && t_instr_ready;
    assign w_capture     = w_accept && w_is_mem && !w_trap;

    always_comb begin
        w_st_wstrb = 4'hF;
        w_st_wdata = rs2Value;
        case (w_funct3)
            3'b000: begin
                w_st_wstrb = 4'b0001 << alu_result[1:0];
                w_st_wdata = {4{rs2Value[7:0]}};
            end
            3'b001: begin
                w_st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{rs2Value[15:0]}};
            end
            default: begin
                w_st_wstrb = 4'hF;
                w_st_wdata = rs2Value;
            end
        endcase
    end

    assign w_txn_funct3 = r_txn_instr[14:12];

    always_comb begin
        w_ld_byte = dbus.dbus_rdata[7:0];
        case (r_txn_addr[1:0])
            2'd0:    w_ld_byte = dbus.dbus_rdata[7:0];
            2'd1:    w_ld_byte = dbus.dbus_rdata[15:8];
            2'd2:    w_ld_byte = dbus.dbus_rdata[23:16];
            default: w_ld_byte = dbus.dbus_rdata[31:24];
        endcase
        w_ld_half = r_txn_addr[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
        case (w_txn_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = dbus.dbus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        w_out_instr  = r_txn_instr;
        w_out_pc     = r_txn_pc;
        w_out_op     = r_txn_op;
        w_out_rd     = 32'd0;
        w_out_mis    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem && !w_trap) begin
                        w_state_next = REQ;
                    end else begin
                        w_load_out  = 1'b1;
                        w_out_instr = t_instr;
                        w_out_pc    = iPC;
                        w_out_op    = iDecodedOP;
                        w_out_rd    = alu_result;
                        w_out_mis   = w_trap;
                    end
                end
            end
            REQ: begin
                if (dbus.dbus_req_ready) begin
                    if (r_txn_we) begin
                        w_state_next = IDLE;
                        w_load_out   = 1'b1;
                    end else begin
                        w_state_next = RSP;
                    end
                end
            end
            RSP: begin
                if (dbus.dbus_rsp_valid) begin
                    w_state_next = IDLE;
                    w_load_out   = 1'b1;
                    w_out_rd     = w_ld_data;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            r_txn_instr <= 32'd0;
            r_txn_pc    <= 32'd0;
            r_txn_op    <= 5'd0;
            r_txn_addr  <= 32'd0;
            r_txn_wdata <= 32'd0;
            r_txn_wstrb <= 4'd0;
            r_txn_we    <= 1'b0;
        end else if (w_capture) begin
            r_txn_instr <= t_instr;
            r_txn_pc    <= iPC;
            r_txn_op    <= iDecodedOP;
            r_txn_addr  <= alu_result;
            r_txn_wdata <= w_is_store ? w_st_wdata : 32'd0;
            r_txn_wstrb <= w_is_store ? w_st_wstrb : 4'd0;
            r_txn_we    <= w_is_store;
        end
    end

    // A load into the entry wins over a same-cycle drain, keeping the entry full.
    always_ff @(posedge clk) begin
        if (rstf) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_pc    <= 32'd0;
            r_out_op    <= 5'd0;
            r_out_rd    <= 32'd0;
            r_out_mis   <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_out_instr;
            r_out_pc    <= w_out_pc;
            r_out_op    <= w_out_op;
            r_out_rd    <= w_out_rd;
            r_out_mis   <= w_out_mis;
        end else if (i_instr_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign dbus.dbus_req_valid = (r_state == REQ);
    assign dbus.dbus_addr      = {r_txn_addr[31:2], 2'b00};
    assign dbus.dbus_wdata     = r_txn_wdata;
    assign dbus.dbus_wstrb     = r_txn_wstrb;
    assign dbus.dbus_we        = r_txn_we;

    assign i_instr_valid = r_out_valid;
    assign i_instr       = r_out_instr;
    assign oPC           = r_out_pc;
    assign oDecodedOP    = r_out_op;
    assign maAlu_rdValue = r_out_rd;
    assign ma_misaligned = r_out_mis;

endmodule

// File: tb/tb_instruction_memaccess.sv
// Directed bench for instruction_memaccess: pass-through, loads, stores, backpressure, reset, alignment.
module tb_instruction_memaccess;

    logic        clk;
    logic        rstf;
    logic [31:0] t_instr;
    logic        t_instr_valid;
    logic        t_instr_ready;
    logic [31:0] iPC;
    logic [4:0]  iDecodedOP;
    logic [31:0] alu_result;
    logic [31:0] rs2Value;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        i_instr_ready;
    logic [31:0] oPC;
    logic [4:0]  oDecodedOP;
    logic [31:0] maAlu_rdValue;
    logic        ma_misaligned;

    int tests = 0;
    int fails = 0;

    instruction_memaccess_if u_bus ();

    instruction_memaccess dut (
        .clk           (clk),
        .rstf          (rstf),
        .t_instr       (t_instr),
        .t_instr_valid (t_instr_valid),
        .t_instr_ready (t_instr_ready),
        .iPC           (iPC),
        .iDecodedOP    (iDecodedOP),
        .alu_result    (alu_result),
        .rs2Value      (rs2Value),
        .dbus          (u_bus),
        .i_instr       (i_instr),
        .i_instr_valid (i_instr_valid),
        .i_instr_ready (i_instr_ready),
        .oPC           (oPC),
        .oDecodedOP    (oDecodedOP),
        .maAlu_rdValue (maAlu_rdValue),
        .ma_misaligned (ma_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstf = 1'b1;
        t_instr = 32'h0000_0033; t_instr_valid = 1'b1;
        iPC = 32'h0; iDecodedOP = 5'd0; alu_result = 32'h0; rs2Value = 32'h0;
        i_instr_ready = 1'b1;
        u_bus.dbus_req_ready = 1'b0; u_bus.dbus_rsp_valid = 1'b0; u_bus.dbus_rdata = 32'h0;
        tick(); tick();
        tests++; if (t_instr_ready !== 1'b0) begin fails++; $display("FAIL rst_t_ready got %b exp 0", t_instr_ready); end
        tests++; if (i_instr_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", i_instr_valid); end
        tests++; if (u_bus.dbus_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", u_bus.dbus_req_valid); end
        tests++; if (maAlu_rdValue !== 32'h0) begin fails++; $display("FAIL rst_rd got %h exp 0", maAlu_rdValue); end
        tests++; if (i_instr !== 32'h0 || oPC !== 32'h0 || oDecodedOP !== 5'd0) begin fails++; $display("FAIL rst_out_regs got %h/%h/%h exp 0", i_instr, oPC, oDecodedOP); end
        tests++; if (ma_misaligned !== 1'b0) begin fails++; $display("FAIL rst_mis got %b exp 0", ma_misaligned); end
        t_instr_valid = 1'b0;
        rstf = 1'b0;
    endtask

    task automatic test_alu();
        t_instr = 32'h0000_0033; alu_result = 32'h1234; iPC = 32'h80; iDecodedOP = 5'd3;
        i_instr_ready = 1'b1; t_instr_valid = 1'b1;
        #1;
        tests++; if (t_instr_ready !== 1'b1) begin fails++; $display("FAIL alu_t_ready got %b exp 1", t_instr_ready); end
        tick();
        t_instr_valid = 1'b0;
        tests++; if (i_instr_valid !== 1'b1) begin fails++; $display("FAIL alu_valid got %b exp 1", i_instr_valid); end
        tests++; if (maAlu_rdValue !== 32'h1234) begin fails++; $display("FAIL alu_rd got %h exp 00001234", maAlu_rdValue); end
        tests++; if (oPC !== 32'h80 || oDecodedOP !== 5'd3 || i_instr !== 32'h33) begin fails++; $display("FAIL alu_meta got %h/%h/%h exp 80/3/33", oPC, oDecodedOP, i_instr); end
        tests++; if (u_bus.dbus_req_valid !== 1'b0) begin fails++; $display("FAIL alu_no_req got %b exp 0", u_bus.dbus_req_valid); end
        tick();
        tests++; if (i_instr_valid !== 1'b0) begin fails++; $display("FAIL alu_drain got %b exp 0", i_instr_valid); end
    endtask

    task automatic test_load();
        logic [31:0] ld_instr [5];
        logic [31:0] ld_addr  [5];
        logic [31:0] ld_exp   [5];
        ld_instr = '{32'h0000_0003, 32'h0000_4003, 32'h0000_1003, 32'h0000_5003, 32'h0000_2003};
        ld_addr  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        ld_exp   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_0000};
        u_bus.dbus_req_ready = 1'b1; u_bus.dbus_rsp_valid = 1'b1; u_bus.dbus_rdata = 32'h80FF_0000;
        i_instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t_instr = ld_instr[i]; alu_result = ld_addr[i]; iPC = 32'h1000 + 32'(i * 4);
            iDecodedOP = 5'(i + 8); t_instr_valid = 1'b1;
            tick();
            t_instr_valid = 1'b0;
            tests++; if (u_bus.dbus_req_valid !== 1'b1 || u_bus.dbus_addr !== 32'h100 || u_bus.dbus_we !== 1'b0) begin
                fails++; $display("FAIL ld_req[%0d] got v=%b a=%h we=%b exp 1/100/0", i, u_bus.dbus_req_valid, u_bus.dbus_addr, u_bus.dbus_we); end
            tests++; if (i_instr_valid !== 1'b0) begin fails++; $display("FAIL ld_early[%0d] got %b exp 0", i, i_instr_valid); end
            tick();
            tests++; if (i_instr_valid !== 1'b0 || u_bus.dbus_req_valid !== 1'b0) begin
                fails++; $display("FAIL ld_rsp_wait[%0d] got v=%b rq=%b exp 0/0", i, i_instr_valid, u_bus.dbus_req_valid); end
            tick();
            tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== ld_exp[i]) begin
                fails++; $display("FAIL ld_data[%0d] got v=%b d=%h exp 1/%h", i, i_instr_valid, maAlu_rdValue, ld_exp[i]); end
            tests++; if (oPC !== 32'h1000 + 32'(i * 4) || i_instr !== ld_instr[i]) begin
                fails++; $display("FAIL ld_meta[%0d] got pc=%h ins=%h exp %h/%h", i, oPC, i_instr, 32'h1000 + 32'(i * 4), ld_instr[i]); end
            tick();
            tests++; if (i_instr_valid !== 1'b0) begin fails++; $display("FAIL ld_drain[%0d] got %b exp 0", i, i_instr_valid); end
        end
        u_bus.dbus_rsp_valid = 1'b0;
    endtask

    task automatic test_store();
        logic [31:0] st_instr [3];
        logic [31:0] st_addr  [3];
        logic [31:0] st_data  [3];
        logic [31:0] st_wdata [3];
        logic [3:0]  st_wstrb [3];
        logic [31:0] st_baddr [3];
        st_instr = '{32'h0000_1023, 32'h0000_0023, 32'h0000_2023};
        st_addr  = '{32'h202, 32'h201, 32'h304};
        st_data  = '{32'hABCD_1234, 32'h0000_00AB, 32'hDEAD_BEEF};
        st_wdata = '{32'h1234_1234, 32'hABAB_ABAB, 32'hDEAD_BEEF};
        st_wstrb = '{4'b1100, 4'b0010, 4'b1111};
        st_baddr = '{32'h200, 32'h200, 32'h304};
        i_instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_bus.dbus_req_ready = (i != 0);
            t_instr = st_instr[i]; alu_result = st_addr[i]; rs2Value = st_data[i];
            iPC = 32'h2000 + 32'(i * 4); iDecodedOP = 5'd20; t_instr_valid = 1'b1;
            tick();
            t_instr_valid = 1'b0;
            tests++; if (u_bus.dbus_req_valid !== 1'b1 || u_bus.dbus_we !== 1'b1 || u_bus.dbus_addr !== st_baddr[i]) begin
                fails++; $display("FAIL st_req[%0d] got v=%b we=%b a=%h exp 1/1/%h", i, u_bus.dbus_req_valid, u_bus.dbus_we, u_bus.dbus_addr, st_baddr[i]); end
            tests++; if (u_bus.dbus_wstrb !== st_wstrb[i] || u_bus.dbus_wdata !== st_wdata[i]) begin
                fails++; $display("FAIL st_lanes[%0d] got s=%b d=%h exp %b/%h", i, u_bus.dbus_wstrb, u_bus.dbus_wdata, st_wstrb[i], st_wdata[i]); end
            tests++; if (t_instr_ready !== 1'b0) begin fails++; $display("FAIL st_t_ready[%0d] got %b exp 0", i, t_instr_ready); end
            if (i == 0) begin
                u_bus.dbus_req_ready = 1'b1;
            end
            tick();
            tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== 32'h0 || i_instr !== st_instr[i]) begin
                fails++; $display("FAIL st_done[%0d] got v=%b d=%h ins=%h exp 1/0/%h", i, i_instr_valid, maAlu_rdValue, i_instr, st_instr[i]); end
            tests++; if (u_bus.dbus_req_valid !== 1'b0) begin fails++; $display("FAIL st_req_drop[%0d] got %b exp 0", i, u_bus.dbus_req_valid); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        u_bus.dbus_req_ready = 1'b0; u_bus.dbus_rsp_valid = 1'b1; u_bus.dbus_rdata = 32'hCAFE_F00D;
        i_instr_ready = 1'b0;
        t_instr = 32'h0000_2003; alu_result = 32'h400; iPC = 32'h40; iDecodedOP = 5'd5; t_instr_valid = 1'b1;
        tick();
        t_instr = 32'h0000_0033; alu_result = 32'h5555; iPC = 32'h44; iDecodedOP = 5'd7;
        for (int k = 0; k < 5; k++) begin
            tests++; if (u_bus.dbus_req_valid !== 1'b1 || u_bus.dbus_addr !== 32'h400 || u_bus.dbus_we !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b a=%h we=%b exp 1/400/0", k, u_bus.dbus_req_valid, u_bus.dbus_addr, u_bus.dbus_we); end
            tests++; if (t_instr_ready !== 1'b0) begin fails++; $display("FAIL bp_t_ready[%0d] got %b exp 0", k, t_instr_ready); end
            tick();
        end
        u_bus.dbus_req_ready = 1'b1;
        tick();
        tests++; if (t_instr_ready !== 1'b0 || i_instr_valid !== 1'b0) begin
            fails++; $display("FAIL bp_rsp got rdy=%b v=%b exp 0/0", t_instr_ready, i_instr_valid); end
        tick();
        tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== 32'hCAFE_F00D || oPC !== 32'h40) begin
            fails++; $display("FAIL bp_load got v=%b d=%h pc=%h exp 1/cafef00d/40", i_instr_valid, maAlu_rdValue, oPC); end
        tests++; if (t_instr_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b exp 0", t_instr_ready); end
        tick();
        tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL bp_held got v=%b d=%h exp 1/cafef00d", i_instr_valid, maAlu_rdValue); end
        i_instr_ready = 1'b1;
        #1;
        tests++; if (t_instr_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b exp 1", t_instr_ready); end
        tick();
        t_instr_valid = 1'b0;
        tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== 32'h5555 || oPC !== 32'h44 || oDecodedOP !== 5'd7) begin
            fails++; $display("FAIL b2b_swap got v=%b d=%h pc=%h op=%h exp 1/5555/44/7", i_instr_valid, maAlu_rdValue, oPC, oDecodedOP); end
        tick();
        tests++; if (i_instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", i_instr_valid); end
        u_bus.dbus_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        u_bus.dbus_req_ready = 1'b1; u_bus.dbus_rsp_valid = 1'b0; u_bus.dbus_rdata = 32'h1111_2222;
        i_instr_ready = 1'b1;
        t_instr = 32'h0000_0003; alu_result = 32'h100; iPC = 32'h50; t_instr_valid = 1'b1;
        tick();
        t_instr_valid = 1'b0;
        tick();
        tests++; if (u_bus.dbus_req_valid !== 1'b0 || i_instr_valid !== 1'b0) begin
            fails++; $display("FAIL rm_in_rsp got rq=%b v=%b exp 0/0", u_bus.dbus_req_valid, i_instr_valid); end
        rstf = 1'b1;
        tick();
        tests++; if (t_instr_ready !== 1'b0) begin fails++; $display("FAIL rm_rst_ready got %b exp 0", t_instr_ready); end
        rstf = 1'b0;
        u_bus.dbus_rsp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (i_instr_valid !== 1'b0 || u_bus.dbus_req_valid !== 1'b0) begin
                fails++; $display("FAIL rm_late_rsp[%0d] got v=%b rq=%b exp 0/0", k, i_instr_valid, u_bus.dbus_req_valid); end
        end
        tests++; if (t_instr_ready !== 1'b1) begin fails++; $display("FAIL rm_idle got %b exp 1", t_instr_ready); end
        u_bus.dbus_rsp_valid = 1'b0;
    endtask

    task automatic test_misalign();
        u_bus.dbus_req_ready = 1'b1; u_bus.dbus_rsp_valid = 1'b1; u_bus.dbus_rdata = 32'h1122_3344;
        i_instr_ready = 1'b1;
        t_instr = 32'h0000_2003; alu_result = 32'h301; iPC = 32'h60; iDecodedOP = 5'd9; t_instr_valid = 1'b1;
        tick();
        t_instr_valid = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
        tests++; if (u_bus.dbus_req_valid !== 1'b0) begin fails++; $display("FAIL mis_no_req got %b exp 0", u_bus.dbus_req_valid); end
        tests++; if (i_instr_valid !== 1'b1 || ma_misaligned !== 1'b1 || maAlu_rdValue !== 32'h301) begin
            fails++; $display("FAIL mis_trap got v=%b m=%b d=%h exp 1/1/301", i_instr_valid, ma_misaligned, maAlu_rdValue); end
        tick();
        tests++; if (i_instr_valid !== 1'b0 || u_bus.dbus_req_valid !== 1'b0) begin
            fails++; $display("FAIL mis_after got v=%b rq=%b exp 0/0", i_instr_valid, u_bus.dbus_req_valid); end
`else
        tests++; if (u_bus.dbus_req_valid !== 1'b1 || u_bus.dbus_addr !== 32'h300) begin
            fails++; $display("FAIL mis_req got v=%b a=%h exp 1/300", u_bus.dbus_req_valid, u_bus.dbus_addr); end
        tick();
        tick();
        tests++; if (i_instr_valid !== 1'b1 || maAlu_rdValue !== 32'h1122_3344 || ma_misaligned !== 1'b0) begin
            fails++; $display("FAIL mis_word got v=%b d=%h m=%b exp 1/11223344/0", i_instr_valid, maAlu_rdValue, ma_misaligned); end
        tick();
`endif
        u_bus.dbus_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
